// File: rtl/dual_port_ram_ctrl.sv
// Dual-port word RAM for the RISC-V core: read-only fetch port A, byte-lane load/store port B,
// post-reset sequential clear, selectable read latency and misalignment error pulses.
module dual_port_ram_ctrl #(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter int                READ_LAT   = 1,
    parameter logic [DATA_W-1:0] RESET_WORD = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  a_req,
    input  logic [31:0]           a_addr,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_rvalid,
    output logic                  a_err,
    input  logic                  b_req,
    input  logic [DATA_W/8-1:0]   b_we,
    input  logic [31:0]           b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid,
    output logic                  b_err,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state_r, state_next_s;
    logic [ADDR_W-1:0]   clr_cnt_r, clr_cnt_next_s;
    logic                ready_r, ready_next_s;
    logic                clr_en_s;

    logic [ADDR_W-1:0]   a_idx_s, b_idx_s;
    logic                a_acc_s, b_acc_s, a_mis_s, b_mis_s, b_full_s;
    logic                a_rd_s, a_err_s, b_rd_s, b_wr_s, b_err_s;

    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                a_v1_r, b_v1_r, a_err_r, b_err_r;
    logic [DATA_W-1:0]   a_d1_r, b_d1_r, dbg_r;
    logic                a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;

    logic                unused_s;
    assign unused_s = ^{a_addr[31:ADDR_W+2], b_addr[31:ADDR_W+2]};

    // Clear-sequence state, counter and ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_W{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
            ready_r   <= ready_next_s;
        end
    end

    // Clear one word per cycle; enter RUN once the last word has been written
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        ready_next_s   = ready_r;
        clr_en_s       = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clr_en_s       = ~reset;
                clr_cnt_next_s = clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (clr_cnt_r == {ADDR_W{1'b1}}) begin
                    state_next_s = ST_RUN;
                    ready_next_s = 1'b1;
                end else begin
                    state_next_s = ST_CLEAR;
                    ready_next_s = 1'b0;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
                ready_next_s = 1'b1;
            end
            default: begin
                state_next_s   = ST_CLEAR;
                clr_cnt_next_s = {ADDR_W{1'b0}};
                ready_next_s   = 1'b0;
            end
        endcase
    end

    // Request decode; partial-lane B writes take their lanes from b_we, so only full-word B accesses can be misaligned
    always_comb begin
        a_idx_s  = a_addr[ADDR_W+1:2];
        b_idx_s  = b_addr[ADDR_W+1:2];
        b_full_s = (b_we == {NB{1'b1}}) || (b_we == {NB{1'b0}});
        a_mis_s  = (a_addr[1:0] != 2'b00);
        b_mis_s  = b_full_s && (b_addr[1:0] != 2'b00);
        if (ready_r && !reset) begin
            a_acc_s = a_req;
            b_acc_s = b_req;
        end else begin
            a_acc_s = 1'b0;
            b_acc_s = 1'b0;
        end
        a_rd_s  = a_acc_s && !a_mis_s;
        a_err_s = a_acc_s && a_mis_s;
        b_rd_s  = b_acc_s && !b_mis_s && (b_we == {NB{1'b0}});
        b_wr_s  = b_acc_s && !b_mis_s && (b_we != {NB{1'b0}});
        b_err_s = b_acc_s && b_mis_s;
    end

    // Memory array: clear writes zeros, otherwise per-lane port B writes
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            mem_r[clr_cnt_r] <= {DATA_W{1'b0}};
        end else if (b_wr_s) begin
            for (int k = 0; k < NB; k++) begin
                if (b_we[k]) begin
                    mem_r[b_idx_s][8*k +: 8] <= b_wdata[8*k +: 8];
                end
            end
        end
    end

    // First read stage, error pulses and debug tap; reads see the pre-write word (read-first)
    always_ff @(posedge clk) begin
        if (reset) begin
            a_v1_r  <= 1'b0;
            b_v1_r  <= 1'b0;
            a_d1_r  <= RESET_WORD;
            b_d1_r  <= RESET_WORD;
            a_err_r <= 1'b0;
            b_err_r <= 1'b0;
            dbg_r   <= {DATA_W{1'b0}};
        end else begin
            a_v1_r  <= a_rd_s;
            b_v1_r  <= b_rd_s;
            a_err_r <= a_err_s;
            b_err_r <= b_err_s;
            dbg_r   <= mem_r[dbg_addr];
            if (a_rd_s) begin
                a_d1_r <= mem_r[a_idx_s];
            end
            if (b_rd_s) begin
                b_d1_r <= mem_r[b_idx_s];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            // Extra output stage; data holds whenever the stage carries no valid read
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_rvalid_q <= 1'b0;
                    b_rvalid_q <= 1'b0;
                    a_rdata_q  <= RESET_WORD;
                    b_rdata_q  <= RESET_WORD;
                end else begin
                    a_rvalid_q <= a_v1_r;
                    b_rvalid_q <= b_v1_r;
                    if (a_v1_r) begin
                        a_rdata_q <= a_d1_r;
                    end
                    if (b_v1_r) begin
                        b_rdata_q <= b_d1_r;
                    end
                end
            end
        end else begin : g_lat1
            assign a_rvalid_q = a_v1_r;
            assign b_rvalid_q = b_v1_r;
            assign a_rdata_q  = a_d1_r;
            assign b_rdata_q  = b_d1_r;
        end
    endgenerate

    assign ready    = ready_r;
    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;
    assign a_err    = a_err_r;
    assign b_err    = b_err_r;
    assign dbg_data = dbg_r;

endmodule

// File: doc/dual_port_ram_ctrl.md
Name: dual_port_ram_ctrl

Overview:
Parametrised dual-port word RAM for the RISC-V core, serving two ports:
- Port A: read-only instruction fetch.
- Port B: load/store with true per-byte write lanes.
It adds three things to a plain RAM: a sequential clear state machine after reset, configurable read latency with valid strobes, and misalignment error reporting. It sits between the core's fetch/memory stages and the on-chip memory array.

Parameters:
ADDR_W, 10, word-address bits; DEPTH = 2**ADDR_W words
DATA_W, 32, word width; must be a multiple of 8; NB = DATA_W/8 byte lanes
READ_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register stage)
RESET_WORD, 32'h00000013, value driven on a_rdata/b_rdata during reset and clear (RV32 NOP)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ready  out  1  high once the clear sequence completes; requests are ignored while low
a_req  in  1  port A read request
a_addr  in  32  port A byte address
a_rdata  out  DATA_W  port A read data
a_rvalid  out  1  port A read-data valid strobe
a_err  out  1  port A misaligned-request pulse
b_req  in  1  port B request
b_we  in  NB  byte-lane write enables; all zero means read
b_addr  in  32  port B byte address
b_wdata  in  DATA_W  port B write data
b_rdata  out  DATA_W  port B read data
b_rvalid  out  1  port B read-data valid strobe
b_err  out  1  port B misaligned-request pulse
dbg_addr  in  ADDR_W  debug word index
dbg_data  out  DATA_W  registered contents of mem[dbg_addr], one cycle latency

Behaviour:
- Reset: clk rising edge with reset=1 forces state CLEAR and clr_cnt=0. Output values during reset:
  - ready=0
  - a_rdata = b_rdata = RESET_WORD
  - a_rvalid, b_rvalid, a_err, b_err = 0
  - dbg_data = 0
  - All in-flight READ_LAT pipeline stages are flushed.
- CLEAR state:
  - Each cycle writes mem[clr_cnt] = 0, then clr_cnt increments.
  - When clr_cnt == DEPTH-1 is written, the next state is RUN and ready=1 from the following cycle. Clear takes exactly DEPTH cycles after reset deasserts.
  - Reset asserted mid-clear restarts at clr_cnt=0.
  - a_req/b_req are ignored: no rvalid, no err, no write.
- RUN state: stays in RUN until reset.
- Address decode:
  - Word index = addr[ADDR_W+1:2].
  - Address bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH*4.
- Misalignment:
  - A request is misaligned when addr[1:0] != 0. Port A always checks this. Port B checks it for full-word access only (b_we all ones or all zero).
  - Port B partial-lane writes with addr[1:0] != 0 are legal; lanes come from b_we directly, and addr[1:0] is ignored.
  - A misaligned request is dropped: no write, no rvalid. The matching err pulses high for 1 cycle, 1 cycle after the request.
- Port A read: a_req accepted in cycle N gives a_rvalid=1 in cycle N+READ_LAT, with a_rdata = mem word as of cycle N.
- Port B read (b_we == 0): same timing as port A, with b_rdata/b_rvalid.
- Port B write (b_we != 0):
  - Lane k (bits 8k+7:8k) is updated from b_wdata only where b_we[k]=1; other lanes keep their old value.
  - b_rvalid stays 0 and b_rdata holds its value.
- rdata outputs hold their last value whenever rvalid=0.
- Collision (A reads word W while B writes W in the same cycle): read-first. Port A returns the old word; the new value is visible to any read accepted on the following cycle.
- Back-to-back requests on both ports are accepted every cycle with full throughput; there is no stall output.
- dbg_data = mem[dbg_addr] registered each cycle. It reads 0 during CLEAR for words already cleared.

Test Plan:
- Reset, then hold reset low: ready rises exactly DEPTH (1024) cycles later. Port reads issued before that produce no a_rvalid or b_rvalid.
- After ready, B write 32'hDEADBEEF to 0x40 with b_we=4'b1111. Then A read 0x40 gives a_rdata=32'hDEADBEEF with a_rvalid at READ_LAT, checked for both READ_LAT=1 and READ_LAT=2.
- From mem[0x40]=32'hDEADBEEF, B write b_wdata=32'h11223344 with b_we=4'b0101. A following B read gives 32'hDE22BE44.
- Same-cycle A read and B write to 0x80: old contents 0, new 32'hCAFEF00D. A returns 0; an A read on the next cycle returns 32'hCAFEF00D.
- A read of 0x42 and B full-word read of 0x83: a_err and b_err each pulse for 1 cycle. No rvalid, and memory is unchanged.
- Wrap-around: write 0x1000+0x10 (ADDR_W=10) and read 0x10, which returns the written data. Reset asserted mid-clear at clr_cnt=500 makes ready come DEPTH cycles after the reset release.
